// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit.
//
// Accepts one byte/half/word request from IDLE, rejects misaligned requests
// with a one-cycle misalign pulse, otherwise holds a word-aligned memory
// request until mem_ack, then reports completion with a one-cycle done pulse
// and the lane-selected, extended load result.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               request pulse (only looked at in IDLE)
//   we, size, uns       store/load, 00 byte 01 half 10 word 11 illegal, zero-ext
//   addr, wdata         effective address, store data (low bits significant)
//   mem_req/mem_we      memory request and write strobe
//   mem_addr/mem_be     word address and byte enables
//   mem_wdata           lane-replicated store data
//   mem_ack/mem_rdata   completion and read word (same cycle)
//   busy, done          not-IDLE flag, completion pulse
//   rdata               load result (0 for stores), held after done
//   misalign            rejection pulse
// ---------------------------------------------------------------------------
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0] state;

  // Request attributes kept for the load-result path.
  logic [1:0] lat_size;
  logic       lat_uns;
  logic [1:0] lat_off;

  // Request decode from the live inputs; only consumed on the accepting edge.
  logic                                mis_c;
  logic [NUM_LANES-1:0]                be_c;
  logic [NUM_LANES-1:0][LANE_W-1:0]    wdata_c;

  always_comb begin
    mis_c = 1'b0;
    be_c  = 4'b1111;
    case (size)
      2'b00: be_c = 4'b0001 << addr[1:0];
      2'b01: begin
        be_c  = 4'b0011 << addr[1:0];
        mis_c = addr[0];
      end
      2'b10: mis_c = (addr[1:0] != 2'b00);
      default: mis_c = 1'b1;
    endcase
  end

  // Each byte lane picks the source byte that lands on it after replication:
  // byte -> always byte 0, half -> byte (lane mod 2), word -> its own byte.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_comb begin
      case (size)
        2'b00:   wdata_c[l] = wdata[7:0];
        2'b01:   wdata_c[l] = wdata[LANE_W*(l%2) +: LANE_W];
        default: wdata_c[l] = wdata[LANE_W*l +: LANE_W];
      endcase
    end
  end

  // Load result: bring the addressed lane down to bit 0, then extend.
  logic [31:0] shifted;
  logic [31:0] ld_c;

  always_comb begin
    shifted = mem_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b00:   ld_c = {{24{~lat_uns & shifted[7]}},  shifted[7:0]};
      2'b01:   ld_c = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
      default: ld_c = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_off   <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 32'h0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            lat_size <= size;
            lat_uns  <= uns;
            lat_off  <= addr[1:0];
            if (mis_c) begin
              // Rejected: flag it and never touch the memory port.
              state    <= S_ERR;
              misalign <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        S_REQ: begin
          // Memory port fields hold their values; wait as long as it takes.
          if (mem_ack) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            rdata   <= mem_we ? 32'h0 : ld_c;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          misalign <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
